// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - mips32 instruction fetch front end with redirect, HLT stop and decode FIFO
//
// Issues word reads to a one-cycle synchronous instruction memory and buffers
// the returned words with their next-PC in a DEPTH-entry FIFO for decode.
//
// Ports:
//   clk1, rst            clock, synchronous active-high reset
//   imem_req/imem_addr   read request and word address (address is fetch_pc)
//   imem_rdata           read data, one cycle after imem_req
//   redirect/redirect_pc taken-branch flush and new fetch address
//   out_valid/out_ready  decode handshake; out_ir/out_npc are the head entry
//   fetch_pc             next address to fetch
//   count                FIFO occupancy
//   halted               fetch stopped after an HLT word
module mips32_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int AW       = 10,
    parameter int RESET_PC = 0
) (
    input  logic                         clk1,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [AW-1:0]                imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         redirect,
    input  logic [AW-1:0]                redirect_pc,
    output logic                         out_valid,
    output logic [31:0]                  out_ir,
    output logic [31:0]                  out_npc,
    input  logic                         out_ready,
    output logic [AW-1:0]                fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [5:0] HLT_OP = 6'b111111;

    logic [AW-1:0] pc;
    logic          inflight;
    logic [AW-1:0] inflight_addr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          halted_q;

    logic [31:0]   ir_mem  [DEPTH];
    logic [AW:0]   npc_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic [AW:0]   resp_npc;
    logic          push;
    logic          pop;
    logic          hlt_hit;

    // Credit check counts the in-flight word as already occupying a slot,
    // so a response always finds room; a same-cycle pop is not credited.
    assign occupancy = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    assign imem_req  = !rst && !halted_q && !redirect && (occupancy < (CW+1)'(DEPTH));

    // npc keeps the carry out of the top address so the word at 2^AW-1 reports 2^AW.
    assign resp_npc  = {1'b0, inflight_addr} + (AW+1)'(1);
    assign push      = inflight && !redirect;
    assign hlt_hit   = push && (imem_rdata[31:26] == HLT_OP);
    assign pop       = out_valid && out_ready && !redirect;

    assign out_valid = (cnt != '0);
    assign out_ir    = ir_mem[rd_ptr];
    assign out_npc   = 32'(npc_mem[rd_ptr]);
    assign imem_addr = pc;
    assign fetch_pc  = pc;
    assign count     = cnt;
    assign halted    = halted_q;

    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr]  <= imem_rdata;
            npc_mem[wr_ptr] <= resp_npc;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc            <= AW'(RESET_PC);
            inflight      <= 1'b0;
            inflight_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            halted_q      <= 1'b0;
        end else if (redirect) begin
            // Flush wins over everything, including an HLT arriving this cycle.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            if (hlt_hit) begin
                // Rewind PC to just past the HLT and squash the request that
                // went out alongside it.
                halted_q <= 1'b1;
                pc       <= resp_npc[AW-1:0];
                inflight <= 1'b0;
            end else if (imem_req) begin
                pc            <= pc + AW'(1);
                inflight      <= 1'b1;
                inflight_addr <= pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb/tb_mips32_fetch_queue.sv - directed table and sequence bench for mips32_fetch_queue
module tb_mips32_fetch_queue;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        redirect;
    logic [9:0]  redirect_pc;

    logic        req_a, valid_a, halted_a;
    logic [9:0]  addr_a, pc_a;
    logic [31:0] rdata_a, ir_a, npc_a;
    logic [2:0]  count_a;

    logic        req_b, valid_b, halted_b;
    logic [9:0]  addr_b, pc_b;
    logic [31:0] rdata_b, ir_b, npc_b;
    logic [2:0]  count_b;
    logic        redirect_b = 1'b0;
    logic [9:0]  redirect_pc_b = 10'd0;

    logic [31:0] tb_mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk1 = ~clk1;

    mips32_fetch_queue #(.DEPTH(4), .AW(10), .RESET_PC(0)) dut_a (
        .clk1(clk1), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(valid_a), .out_ir(ir_a),
        .out_npc(npc_a), .out_ready(out_ready), .fetch_pc(pc_a), .count(count_a), .halted(halted_a)
    );

    mips32_fetch_queue #(.DEPTH(4), .AW(10), .RESET_PC(1022)) dut_b (
        .clk1(clk1), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .out_valid(valid_b), .out_ir(ir_b),
        .out_npc(npc_b), .out_ready(out_ready), .fetch_pc(pc_b), .count(count_b), .halted(halted_b)
    );

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge clk1) begin
        if (req_a) rdata_a <= tb_mem[addr_a];
        if (req_b) rdata_b <= tb_mem[addr_b];
    end

    // Occupancy beyond DEPTH would mean a push into a full FIFO.
    always @(negedge clk1) begin
        if (!rst && (count_a > 3'd4 || count_b > 3'd4)) begin
            n_tests++;
            n_fail++;
            $display("FAIL overflow: count_a=%0d count_b=%0d limit=4", count_a, count_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Follows delivered words: each pop must be the next address in sequence.
    task automatic expect_stream(input bit sel, input int start_addr, input int n);
        int addr = start_addr;
        int got = 0;
        int budget = 0;
        while (got < n && budget < 200) begin
            @(negedge clk1);
            if ((sel ? valid_b : valid_a) && out_ready) begin
                chk("stream_npc", sel ? npc_b : npc_a, 32'(addr + 1));
                chk("stream_ir", sel ? ir_b : ir_a, tb_mem[addr]);
                addr = (addr + 1) % 1024;
                got++;
            end
            @(posedge clk1);
            #1;
            budget++;
        end
        if (got < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d words expected %0d", got, n);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        exp_valid;
        logic [31:0] exp_ir;
        logic [31:0] exp_npc;
        logic [2:0]  exp_count;
        logic        exp_req;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0022_1800 + 32'(i);

        // Streaming from reset: two reset cycles, then one instruction per cycle.
        vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 10'd0};
        vecs[1] = '{1'b1, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 10'd0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 10'd0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 10'd1};
        for (int k = 4; k < 12; k++)
            vecs[k] = '{1'b0, 1'b1, 32'h0022_1800 + 32'(k - 4), 32'(k - 3), 3'd1, 1'b1, 10'(k - 2)};

        rst = 1'b1;
        out_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 10'd0;

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            @(negedge clk1);
            chk($sformatf("v%0d_valid", i), valid_a, vecs[i].exp_valid);
            chk($sformatf("v%0d_count", i), count_a, vecs[i].exp_count);
            chk($sformatf("v%0d_req", i), req_a, vecs[i].exp_req);
            chk($sformatf("v%0d_addr", i), addr_a, vecs[i].exp_addr);
            chk($sformatf("v%0d_halted", i), halted_a, 1'b0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_ir", i), ir_a, vecs[i].exp_ir);
                chk($sformatf("v%0d_npc", i), npc_a, vecs[i].exp_npc);
            end
            @(posedge clk1);
            #1;
        end

        // Backpressure: occupancy saturates at DEPTH, then drains losslessly.
        do_reset();
        out_ready = 1'b0;
        repeat (4) cyc();
        @(negedge clk1);
        chk("bp_count3", count_a, 3'd3);
        chk("bp_req_credit", req_a, 1'b0);
        repeat (6) cyc();
        @(negedge clk1);
        chk("bp_count_sat", count_a, 3'd4);
        chk("bp_req_full", req_a, 1'b0);
        chk("bp_head", ir_a, tb_mem[0]);
        cyc();
        out_ready = 1'b1;
        expect_stream(1'b0, 0, 8);

        // Redirect with three queued words and one in flight.
        do_reset();
        out_ready = 1'b0;
        repeat (4) cyc();
        redirect = 1'b1;
        redirect_pc = 10'h040;
        @(negedge clk1);
        chk("rd_count_pre", count_a, 3'd3);
        chk("rd_req_masked", req_a, 1'b0);
        cyc();
        redirect = 1'b0;
        @(negedge clk1);
        chk("rd_count", count_a, 3'd0);
        chk("rd_valid", valid_a, 1'b0);
        chk("rd_req", req_a, 1'b1);
        chk("rd_addr", addr_a, 10'h040);
        cyc();
        out_ready = 1'b1;
        expect_stream(1'b0, 10'h040, 4);

        // HLT at word 5: words 0..5 delivered, then fetch stays stopped.
        tb_mem[5] = 32'hFC00_0000;
        do_reset();
        out_ready = 1'b1;
        expect_stream(1'b0, 0, 6);
        @(negedge clk1);
        chk("hlt_halted", halted_a, 1'b1);
        chk("hlt_pc", pc_a, 10'd6);
        cyc();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            chk("hlt_req_idle", req_a, 1'b0);
            chk("hlt_no_word6", valid_a, 1'b0);
            cyc();
        end

        // Redirect in the same cycle the HLT word would be pushed.
        do_reset();
        out_ready = 1'b1;
        repeat (6) cyc();
        redirect = 1'b1;
        redirect_pc = 10'h100;
        cyc();
        redirect = 1'b0;
        @(negedge clk1);
        chk("rh_halted", halted_a, 1'b0);
        chk("rh_count", count_a, 3'd0);
        chk("rh_req", req_a, 1'b1);
        chk("rh_addr", addr_a, 10'h100);
        cyc();
        expect_stream(1'b0, 10'h100, 3);
        tb_mem[5] = 32'h0022_1805;

        // Address wrap from 1022, then reset in the middle of the stream.
        do_reset();
        out_ready = 1'b1;
        @(negedge clk1);
        chk("wr_addr0", addr_b, 10'd1022);
        chk("wr_req0", req_b, 1'b1);
        cyc();
        @(negedge clk1);
        chk("wr_addr1", addr_b, 10'd1023);
        cyc();
        chk("wr_addr2", addr_b, 10'd0);
        expect_stream(1'b1, 1022, 5);
        rst = 1'b1;
        @(negedge clk1);
        chk("wr_rst_req", req_b, 1'b0);
        cyc();
        rst = 1'b0;
        @(negedge clk1);
        chk("wr_rst_valid", valid_b, 1'b0);
        chk("wr_rst_count", count_b, 3'd0);
        chk("wr_rst_addr", addr_b, 10'd1022);
        chk("wr_rst_req2", req_b, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_fetch_queue.md
Name: mips32_fetch_queue

Overview:
- Instruction-fetch front end for the mips32 pipeline; sits directly upstream of the ID stage and supplies its instruction/NPC pair.
- Issues word-addressed reads to a synchronous instruction memory.
- Buffers returned words in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles taken-branch redirects from EX/MEM, and stops fetching after an HLT opcode (6'b111111).

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
AW, 10, instruction address width in words (1024-word memory)
RESET_PC, 0, PC value loaded on reset

Ports:
clk1  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  read request this cycle
imem_addr  out  AW  word address of the request (equals fetch_pc)
imem_rdata  in  32  read data, valid exactly one cycle after imem_req
redirect  in  1  taken branch: flush and restart fetch
redirect_pc  in  AW  branch target word address
out_valid  out  1  head entry is valid
out_ir  out  32  head instruction
out_npc  out  32  head instruction address + 1, zero-extended
out_ready  in  1  decode accepts head this cycle
fetch_pc  out  AW  next address to fetch
count  out  $clog2(DEPTH+1)  FIFO occupancy
halted  out  1  fetch stopped by HLT

Behaviour:
- Reset:
  - Values: PC=RESET_PC, count=0, inflight=0, halted=0, FIFO pointers=0.
  - Output state: out_valid=0, imem_req=0.
  - rst mid-operation discards the FIFO and any in-flight response.
- imem_req is combinational: !rst & !halted & !redirect & (count + inflight < DEPTH).
  - The credit check ignores any same-cycle pop.
- Request issue: PC <= PC+1 (mod 2^AW), inflight <= 1, inflight_addr <= PC.
- Response:
  - In the cycle after a request, if inflight is still 1, push {imem_rdata, inflight_addr+1} at the tail.
  - inflight clears unless a new request is issued that cycle.
  - Sustained throughput is 1 instruction/cycle when out_ready=1 and DEPTH >= 2.
- FIFO:
  - out_valid = (count != 0); out_ir/out_npc read combinationally from the head.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push while full cannot occur because of the credit check; the bench asserts this.
- Redirect (highest priority):
  - Action in that cycle: count <= 0, pointers reset, inflight <= 0, PC <= redirect_pc, no request issued.
  - Any response arriving that cycle is dropped; any pop that cycle is ignored.
  - First request to redirect_pc goes out the following cycle.
- HLT:
  - When a pushed word has [31:26]==6'b111111, it is enqueued normally.
  - Same edge: halted <= 1 and PC <= inflight_addr+1.
  - Any request issued in that same cycle is squashed: its response is not pushed and inflight <= 0.
  - While halted: no requests; the FIFO drains normally.
  - redirect still flushes and loads PC but does not clear halted.
  - halted clears only on rst.
- Simultaneous redirect and HLT push: redirect wins; HLT is flushed and halted stays 0.
- PC wraps from 2^AW-1 to 0; out_npc of the word at 2^AW-1 is 2^AW (32-bit, not wrapped).
- All registered outputs update only on clk1 rising edge; there are no asynchronous paths.

Test Plan:
1. Streaming:
   - Stimulus: rst 2 cycles, memory words 0..7 = 0x00221800+i, out_ready=1.
   - Response: imem_req at addr 0 on the first cycle after reset; first out_valid 2 cycles after reset release; out_ir sequence 0x00221800.. with out_npc 1,2,3…; one instruction per cycle.
2. Backpressure:
   - Stimulus: out_ready=0 for 10 cycles.
   - Response: count saturates at 4 (DEPTH); imem_req low once count+inflight=4; no word lost or duplicated after out_ready=1.
3. Redirect:
   - Stimulus: redirect=1, redirect_pc=0x040 while count=3 and a request is in flight.
   - Response: next cycle count=0 and out_valid=0; next request addr 0x040; first delivered out_npc=0x41; stale in-flight word never appears.
4. HLT:
   - Stimulus: word 5 = 0xFC000000.
   - Response: words 0–5 delivered in order; halted=1; fetch_pc=6; word 6 never delivered; imem_req stays 0 for 20 cycles.
5. Redirect coinciding with HLT push:
   - Response: halted=0; fetch resumes at redirect_pc.
6. Address wrap and reset:
   - Stimulus: RESET_PC=1022.
   - Response: fetch sequence 1022, 1023, 0; out_npc=1023, 1024, 1.
   - Then assert rst mid-stream: out_valid=0 and count=0 next cycle; refetch starts at 1022.
